// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: address width, default boot
// window and the controller state encoding.
package boot_loader_pkg;

  localparam int ADDR_W = 18;

  localparam logic [ADDR_W-1:0] DEF_BOOT_START_ADDR = 18'h0C000;
  localparam logic [ADDR_W-1:0] DEF_BOOT_END_ADDR   = 18'h0FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } boot_state_t;

endpackage

// File: rtl/boot_loader_sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous input, plus one-cycle
// rise/fall pulses derived from the synchronised level.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input
//   rise     : pulse, synchronised din went 0->1
//   fall     : pulse, synchronised din went 1->0
module sync_edge #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  // sh[0]: first flop, sh[1]: synchronised level, sh[2]: previous level
  logic [2:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh <= {3{IDLE}};
    else     sh <= {sh[1:0], din};
  end

  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a boot image over the ARM SPI link (mode 3, MSB
// first) and writes it byte by byte into SRAM through the arbiter.
//   clk, reset      : 100 MHz clock, async active-high reset
//   arm_ss/sclk/mosi: asynchronous SPI slave inputs
//   booting         : high until the image is loaded (holds CPU in reset)
//   boot_req/addr/data, boot_ack : SRAM write handshake
//   boot_overflow   : sticky, a byte was dropped (busy or past window end)
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_START_ADDR = DEF_BOOT_START_ADDR,
  parameter logic [ADDR_W-1:0] BOOT_END_ADDR   = DEF_BOOT_END_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_ss,
  input  logic              arm_sclk,
  input  logic              arm_mosi,
  output logic              booting,
  output logic              boot_req,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [7:0]        boot_data,
  input  logic              boot_ack,
  output logic              boot_overflow
);

  boot_state_t state, state_n;

  logic ss_rise, ss_fall, sclk_rise;
  logic unused_sclk_fall;
  logic [1:0] mosi_sync;

  // One extra bit so the counter can sit past the window end without wrapping.
  logic [ADDR_W:0] addr;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      byte_val;
  logic            load_entry;

  sync_edge #(.IDLE(1'b1)) u_ss (
    .clk(clk), .rst(reset), .din(arm_ss), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge #(.IDLE(1'b1)) u_sclk (
    .clk(clk), .rst(reset), .din(arm_sclk), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  // Same two-flop depth as sclk's synchronised level, so the data bit
  // seen with a sclk rise pulse is the one the master set up for that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync <= 2'b11;
    else       mosi_sync <= {mosi_sync[0], arm_mosi};
  end

  assign byte_val = {shreg[6:0], mosi_sync[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_entry = 1'b0;
    case (state)
      ST_IDLE: if (ss_fall) begin state_n = ST_LOAD; load_entry = 1'b1; end
      ST_LOAD: if (ss_rise) state_n = ST_DONE;
      ST_DONE: if (ss_fall) begin state_n = ST_LOAD; load_entry = 1'b1; end
      default: state_n = ST_IDLE;
    endcase
  end

  // Stay in "booting" in DONE until the final write has been taken.
  assign booting = (state != ST_DONE) || boot_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr          <= {1'b0, BOOT_START_ADDR};
      bit_cnt       <= '0;
      shreg         <= '0;
      boot_req      <= 1'b0;
      boot_addr     <= BOOT_START_ADDR;
      boot_data     <= '0;
      boot_overflow <= 1'b0;
    end else begin
      if (boot_req && boot_ack) begin
        boot_req <= 1'b0;
        addr     <= addr + 1'b1;
      end
      if (load_entry) begin
        addr          <= {1'b0, BOOT_START_ADDR};
        bit_cnt       <= '0;
        shreg         <= '0;
        boot_overflow <= 1'b0;
      end else if (state == ST_LOAD && sclk_rise) begin
        // Evaluated even when ss rises this cycle: the last bit still counts.
        shreg   <= byte_val;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (boot_req || addr > {1'b0, BOOT_END_ADDR}) begin
            boot_overflow <= 1'b1;
          end else begin
            boot_req  <= 1'b1;
            boot_addr <= addr[ADDR_W-1:0];
            boot_data <= byte_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader. A small window end (C00F) keeps the
// end-of-window boundary reachable in a short run.
module tb_boot_loader;

  localparam logic [17:0] START = 18'h0C000;
  localparam logic [17:0] END_A = 18'h0C00F;

  logic        clk = 1'b0, reset = 1'b1;
  logic        arm_ss = 1'b1, arm_sclk = 1'b1, arm_mosi = 1'b1;
  logic        boot_ack = 1'b0;
  logic        booting, boot_req, boot_overflow;
  logic [17:0] boot_addr;
  logic [7:0]  boot_data;

  int tests = 0, fails = 0;
  int nwrites = 0;
  logic [17:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic [17:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic        exp_ovf = 1'b0;
  int          ack_lat = 0;
  logic        stray = 1'b0;

  boot_loader #(.BOOT_START_ADDR(START), .BOOT_END_ADDR(END_A)) dut (
    .clk(clk), .reset(reset), .arm_ss(arm_ss), .arm_sclk(arm_sclk),
    .arm_mosi(arm_mosi), .booting(booting), .boot_req(boot_req),
    .boot_addr(boot_addr), .boot_data(boot_data), .boot_ack(boot_ack),
    .boot_overflow(boot_overflow)
  );

  always #5 clk = ~clk;

  // Arbiter: acks ack_lat cycles after a request; 'stray' drives ack while idle.
  int ack_wait = 0;
  always @(negedge clk) begin
    if (reset) begin
      boot_ack = 1'b0; ack_wait = 0;
    end else if (boot_req) begin
      if (ack_wait >= ack_lat) begin boot_ack = 1'b1; ack_wait = 0; end
      else begin boot_ack = 1'b0; ack_wait++; end
    end else begin
      boot_ack = stray; ack_wait = 0;
    end
  end

  // Every cycle: a pending write must hold, an accepted write must match the model.
  always begin : cmp
    logic        pend;
    logic [17:0] p_addr, ea;
    logic [7:0]  p_data, ed;
    pend = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) pend = 1'b0;
      else begin
        if (pend) begin
          tests++;
          if (boot_req !== 1'b1 || boot_addr !== p_addr || boot_data !== p_data) begin
            fails++;
            $display("FAIL hold: req=%b addr=%h data=%h, required req=1 addr=%h data=%h",
                     boot_req, boot_addr, boot_data, p_addr, p_data);
          end
        end
        if (boot_req === 1'b1 && boot_ack === 1'b1) begin
          tests++;
          if (exp_addr_q.size() == 0) begin
            fails++;
            $display("FAIL write: unexpected %h=%h, required no write", boot_addr, boot_data);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (boot_addr !== ea || boot_data !== ed) begin
              fails++;
              $display("FAIL write: got %h=%h, required %h=%h", boot_addr, boot_data, ea, ed);
            end
          end
          nwrites++;
          last_addr = boot_addr;
          last_data = boot_data;
          pend = 1'b0;
        end else begin
          pend   = (boot_req === 1'b1);
          p_addr = boot_addr;
          p_data = boot_data;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Model: byte i of a transfer lands at START+i unless that is past the window end.
  task automatic expect_ramp(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int a;
      a = int'(START) + i;
      if (a <= int'(END_A)) begin
        exp_addr_q.push_back(18'(a));
        exp_data_q.push_back(base + 8'(i));
      end else exp_ovf = 1'b1;
    end
  endtask

  task automatic push_w(input logic [17:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Keeps SPI activity 2 ns clear of clock edges.
  task automatic align();
    @(posedge clk); #2;
  endtask

  // 20 MHz SPI, mosi set on the falling edge; optionally raise ss with the last rise.
  task automatic spi_bits(input logic [7:0] b, input int n, input bit ss_with_last);
    for (int i = 7; i > 7 - n; i--) begin
      arm_sclk = 1'b0; arm_mosi = b[i]; #25;
      arm_sclk = 1'b1;
      if (ss_with_last && i == 8 - n) arm_ss = 1'b1;
      #25;
    end
  endtask

  task automatic ss_start();
    exp_ovf = 1'b0; nwrites = 0;
    arm_ss = 1'b0; #100;
  endtask

  task automatic ss_stop();
    #100; arm_ss = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_addr_q.size() != 0 || boot_req === 1'b1) && n < 400) begin
      @(negedge clk); n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s_drain: timed out with %0d writes outstanding, required 0", name, exp_addr_q.size());
    end
    repeat (10) @(negedge clk);
    align();
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_booting"}, booting, 1);
    chk({name, "_req"}, boot_req, 0);
    chk({name, "_addr"}, boot_addr, START);
    chk({name, "_data"}, boot_data, 0);
    chk({name, "_ovf"}, boot_overflow, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    reset = 1'b0;
    align();

    // Two bytes, ack one cycle after each request.
    ss_start();
    push_w(18'h0C000, 8'hA5);
    push_w(18'h0C001, 8'h3C);
    spi_bits(8'hA5, 8, 0);
    spi_bits(8'h3C, 8, 0);
    #100 chk("t1_booting_during_load", booting, 1);
    ss_stop();
    drain("t1");
    chk("t1_booting", booting, 0);
    chk("t1_ovf", boot_overflow, 0);
    chk("t1_writes", nwrites, 2);

    // Full window with ack also driven while idle (must be ignored).
    stray = 1'b1;
    ss_start();
    expect_ramp(16, 8'hF0);
    for (int i = 0; i < 16; i++) spi_bits(8'hF0 + 8'(i), 8, 0);
    ss_stop();
    drain("t2");
    stray = 1'b0;
    chk("t2_last_addr", last_addr, 18'h0C00F);
    chk("t2_last_data", last_data, 8'hFF);
    chk("t2_writes", nwrites, 16);
    chk("t2_ovf", boot_overflow, exp_ovf);
    chk("t2_booting", booting, 0);

    // One byte past the window end.
    ss_start();
    expect_ramp(17, 8'h10);
    for (int i = 0; i < 17; i++) spi_bits(8'h10 + 8'(i), 8, 0);
    ss_stop();
    drain("t3");
    chk("t3_writes", nwrites, 16);
    chk("t3_ovf_model", boot_overflow, exp_ovf);
    chk("t3_ovf", boot_overflow, 1);
    chk("t3_last_addr", last_addr, 18'h0C00F);
    chk("t3_last_data", last_data, 8'h1F);

    // Arbiter stalls 60 cycles: second byte arrives while busy.
    ack_lat = 60;
    ss_start();
    push_w(18'h0C000, 8'h77);
    spi_bits(8'h77, 8, 0);
    spi_bits(8'h88, 8, 0);
    arm_ss = 1'b1;
    #100;
    chk("t4_booting_pending", booting, 1);
    chk("t4_req_pending", boot_req, 1);
    drain("t4");
    ack_lat = 0;
    chk("t4_writes", nwrites, 1);
    chk("t4_ovf", boot_overflow, 1);
    chk("t4_booting", booting, 0);

    // Partial byte discarded, then re-boot.
    ss_start();
    spi_bits(8'hE0, 5, 0);
    ss_stop();
    drain("t5a");
    chk("t5_partial_writes", nwrites, 0);
    ss_start();
    push_w(18'h0C000, 8'h12);
    spi_bits(8'h12, 8, 0);
    ss_stop();
    drain("t5b");
    chk("t5_writes", nwrites, 1);
    chk("t5_last_addr", last_addr, 18'h0C000);
    chk("t5_last_data", last_data, 8'h12);
    chk("t5_ovf_cleared", boot_overflow, 0);

    // ss rises together with the 8th sclk rise.
    ss_start();
    push_w(18'h0C000, 8'h5A);
    spi_bits(8'h5A, 8, 1);
    #100;
    drain("t6");
    chk("t6_writes", nwrites, 1);
    chk("t6_last_data", last_data, 8'h5A);
    chk("t6_booting", booting, 0);

    // Reset in the middle of a transfer.
    ss_start();
    expect_ramp(3, 8'h01);
    for (int i = 0; i < 3; i++) spi_bits(8'h01 + 8'(i), 8, 0);
    spi_bits(8'hFF, 4, 0);
    #200;
    chk("t7_pre_reset_writes", nwrites, 3);
    reset = 1'b1; arm_ss = 1'b1; arm_sclk = 1'b1; arm_mosi = 1'b1;
    #20 chk_reset("t7_reset");
    reset = 1'b0;
    align();
    ss_start();
    push_w(18'h0C000, 8'h9C);
    spi_bits(8'h9C, 8, 0);
    ss_stop();
    drain("t7");
    chk("t7_writes", nwrites, 1);
    chk("t7_last_addr", last_addr, 18'h0C000);
    chk("t7_last_data", last_data, 8'h9C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
